// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/control bundle between the ID-stage hazard logic and the pipeline registers.
// The pipeline side is the master (supplies decode/EX info); the stall controller is the slave.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_mdu_op;
  logic             id_hilo_read;
  logic             id_jump;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;

  logic             stall;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             mdu_start;
  logic             mdu_busy;
  logic [1:0]       stall_reason;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_op, id_hilo_read,
           id_jump, ex_mem_read, ex_rt, ex_branch_taken,
    input  stall, pc_write, ifid_write, ifid_flush, idex_flush,
           mdu_start, mdu_busy, stall_reason, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_op, id_hilo_read,
           id_jump, ex_mem_read, ex_rt, ex_branch_taken,
    output stall, pc_write, ifid_write, ifid_flush, idex_flush,
           mdu_start, mdu_busy, stall_reason, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use and MDU hazards,
// branch/jump redirects, MDU busy sequencing and a saturating stall counter.
module pipeline_stall_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 16
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int CW = $clog2(MDU_LATENCY + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [CNT_W-1:0] cycles;

  logic       lu, mh, hz, busy;
  logic       stall_int, pc_write_int, ifid_write_int;
  logic       ifid_flush_int, idex_flush_int, mdu_start_int;
  logic [1:0] reason_int;

  assign busy = (state == BUSY) && !reset;

  assign lu = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
              ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt)) ||
               (bus.id_uses_rt && (bus.id_rt == bus.ex_rt)));
  assign mh = busy && (bus.id_mdu_op || bus.id_hilo_read);
  assign hz = lu || mh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      cycles <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (stall_int && (cycles != {CNT_W{1'b1}}))
        cycles <= cycles + 1'b1;
    end
  end

  // A taken branch outranks any hazard; a jump only redirects in an unstalled cycle.
  always_comb begin
    stall_int      = 1'b0;
    pc_write_int   = 1'b1;
    ifid_write_int = 1'b1;
    ifid_flush_int = 1'b0;
    idex_flush_int = 1'b0;
    mdu_start_int  = 1'b0;
    reason_int     = 2'b00;
    state_next     = state;
    cnt_next       = cnt;

    if (!reset) begin
      if (mh)
        reason_int = 2'b10;
      else if (lu)
        reason_int = 2'b01;

      if (bus.ex_branch_taken) begin
        ifid_flush_int = 1'b1;
        idex_flush_int = 1'b1;
      end else if (hz) begin
        stall_int      = 1'b1;
        pc_write_int   = 1'b0;
        ifid_write_int = 1'b0;
      end else begin
        ifid_flush_int = bus.id_jump;
        mdu_start_int  = bus.id_mdu_op;
      end

      case (state)
        IDLE: begin
          if (mdu_start_int) begin
            state_next = BUSY;
            cnt_next   = CW'(MDU_LATENCY);
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign bus.stall        = stall_int;
  assign bus.pc_write     = pc_write_int;
  assign bus.ifid_write   = ifid_write_int;
  assign bus.ifid_flush   = ifid_flush_int;
  assign bus.idex_flush   = idex_flush_int;
  assign bus.mdu_start    = mdu_start_int;
  assign bus.mdu_busy     = busy;
  assign bus.stall_reason = reason_int;
  assign bus.stall_cycles = cycles;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: a reference model pushes expected
// output vectors to a queue when inputs are driven; they are popped at sample time.
module tb_pipeline_stall_ctrl;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             stall;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             mdu_start;
    logic             mdu_busy;
    logic [1:0]       reason;
    logic [CNT_W-1:0] cycles;
  } vec_t;

  logic clk;
  logic reset;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(
    .MDU_LATENCY(MDU_LAT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_busy_left = 0;
  int   m_cycles    = 0;

  function automatic vec_t observe();
    vec_t v;
    v.stall      = bus.stall;
    v.pc_write   = bus.pc_write;
    v.ifid_write = bus.ifid_write;
    v.ifid_flush = bus.ifid_flush;
    v.idex_flush = bus.idex_flush;
    v.mdu_start  = bus.mdu_start;
    v.mdu_busy   = bus.mdu_busy;
    v.reason     = bus.stall_reason;
    v.cycles     = bus.stall_cycles;
    return v;
  endfunction

  function automatic vec_t predict();
    vec_t v;
    logic lu, mh, busy;
    v            = '0;
    v.pc_write   = 1'b1;
    v.ifid_write = 1'b1;
    v.cycles     = CNT_W'(m_cycles);
    if (reset) return v;
    busy       = (m_busy_left != 0);
    v.mdu_busy = busy;
    lu = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
         ((bus.id_uses_rs && bus.id_rs == bus.ex_rt) ||
          (bus.id_uses_rt && bus.id_rt == bus.ex_rt));
    mh = busy && (bus.id_mdu_op || bus.id_hilo_read);
    v.reason = mh ? 2'b10 : (lu ? 2'b01 : 2'b00);
    if (bus.ex_branch_taken) begin
      v.ifid_flush = 1'b1;
      v.idex_flush = 1'b1;
    end else if (lu || mh) begin
      v.stall      = 1'b1;
      v.pc_write   = 1'b0;
      v.ifid_write = 1'b0;
    end else begin
      v.ifid_flush = bus.id_jump;
      v.mdu_start  = bus.id_mdu_op;
    end
    return v;
  endfunction

  task automatic model_step();
    vec_t v;
    v = predict();
    if (reset) begin
      m_busy_left = 0;
      m_cycles    = 0;
    end else begin
      if (v.stall && m_cycles < CNT_MAX) m_cycles++;
      if (m_busy_left > 0) m_busy_left--;
      else if (v.mdu_start) m_busy_left = MDU_LAT;
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs           = 5'd0;
    bus.id_rt           = 5'd0;
    bus.id_uses_rs      = 1'b0;
    bus.id_uses_rt      = 1'b0;
    bus.id_mdu_op       = 1'b0;
    bus.id_hilo_read    = 1'b0;
    bus.id_jump         = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_rt           = 5'd0;
    bus.ex_branch_taken = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rt);
    bus.ex_mem_read = 1'b1;
    bus.ex_rt       = rt;
    bus.id_rs       = 5'd5;
    bus.id_uses_rs  = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    vec_t e, o;
    clear_inputs();
    reset = 1'b1;
    advance();
    set_load_use(5'd5);
    bus.id_mdu_op = 1'b1;
    bus.id_jump   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(predict());
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL reset cyc%0d: got %h want %h", i, o, e);
      end
      advance();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load_use();
    vec_t e, o;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      case (i)
        0: set_load_use(5'd5);
        1: set_load_use(5'd0);
        2: begin
          bus.ex_mem_read = 1'b1;
          bus.ex_rt       = 5'd9;
          bus.id_rt       = 5'd9;
          bus.id_uses_rt  = 1'b1;
        end
        default: begin
          set_load_use(5'd5);
          bus.id_uses_rs = 1'b0;
        end
      endcase
      exp_q.push_back(predict());
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL load_use case%0d: got %h want %h", i, o, e);
      end
      advance();
      if (i == 0) begin
        vectors++;
        if (bus.stall_cycles !== 4'd1) begin
          miscompares++;
          $display("[TB] FAIL load_use_count: got %0d want 1", bus.stall_cycles);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_mdu();
    vec_t e, o;
    int busy_seen, stall_seen;
    do_reset();
    busy_seen  = 0;
    stall_seen = 0;
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      if (i == 0) bus.id_mdu_op = 1'b1;
      else if (i <= 6) bus.id_hilo_read = 1'b1;
      exp_q.push_back(predict());
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL mdu cyc%0d: got %h want %h", i, o, e);
      end
      if (o.mdu_busy === 1'b1) busy_seen++;
      if (o.stall === 1'b1 && o.reason === 2'b10) stall_seen++;
      advance();
    end
    vectors++;
    if (busy_seen != MDU_LAT || stall_seen != MDU_LAT) begin
      miscompares++;
      $display("[TB] FAIL mdu_window: busy %0d stall %0d want %0d", busy_seen, stall_seen, MDU_LAT);
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    vec_t e, o;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      case (i)
        0: begin
          set_load_use(5'd5);
          bus.ex_branch_taken = 1'b1;
        end
        1: bus.id_mdu_op = 1'b1;
        2, 3: begin
          bus.ex_branch_taken = 1'b1;
          bus.id_hilo_read    = 1'b1;
        end
        default: ;
      endcase
      exp_q.push_back(predict());
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL branch cyc%0d: got %h want %h", i, o, e);
      end
      advance();
      if (i == 0) begin
        vectors++;
        if (bus.stall_cycles !== 4'd0) begin
          miscompares++;
          $display("[TB] FAIL branch_no_count: got %0d want 0", bus.stall_cycles);
        end
      end
    end
    clear_inputs();
    for (int i = 0; i < MDU_LAT; i++) advance();
  endtask

  task automatic test_jump();
    vec_t e, o;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      bus.id_jump = 1'b1;
      if (i == 0) set_load_use(5'd5);
      exp_q.push_back(predict());
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      vectors++;
      if (o !== e || o.ifid_flush !== (i == 1)) begin
        miscompares++;
        $display("[TB] FAIL jump cyc%0d: got %h want %h", i, o, e);
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    vec_t e, o;
    do_reset();
    set_load_use(5'd5);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(predict());
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL saturate cyc%0d: got %h want %h", i, o, e);
      end
      advance();
    end
    vectors++;
    if (bus.stall_cycles !== 4'd15) begin
      miscompares++;
      $display("[TB] FAIL saturate_final: got %0d want 15", bus.stall_cycles);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    vec_t e, o;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      reset = 1'b0;
      case (i)
        0: set_load_use(5'd5);
        1: bus.id_mdu_op = 1'b1;
        3: reset = 1'b1;
        4: bus.id_mdu_op = 1'b1;
        default: ;
      endcase
      exp_q.push_back(predict());
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL reset_busy cyc%0d: got %h want %h", i, o, e);
      end
      if (i == 4) begin
        vectors++;
        if (o.mdu_busy !== 1'b0 || o.cycles !== 4'd0 || o.mdu_start !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL reset_busy_reissue: busy %b cycles %0d start %b want 0 0 1",
                   o.mdu_busy, o.cycles, o.mdu_start);
        end
      end
      advance();
    end
    reset = 1'b0;
    clear_inputs();
    for (int i = 0; i < MDU_LAT; i++) advance();
  endtask

  task automatic test_back_to_back();
    vec_t e, o;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      reset               = ($urandom_range(0, 39) == 0);
      bus.id_rs           = 5'($urandom_range(0, 3));
      bus.id_rt           = 5'($urandom_range(0, 3));
      bus.ex_rt           = 5'($urandom_range(0, 3));
      bus.id_uses_rs      = ($urandom_range(0, 1) == 0);
      bus.id_uses_rt      = ($urandom_range(0, 1) == 0);
      bus.ex_mem_read     = ($urandom_range(0, 2) == 0);
      bus.id_mdu_op       = ($urandom_range(0, 4) == 0);
      bus.id_hilo_read    = ($urandom_range(0, 3) == 0);
      bus.id_jump         = ($urandom_range(0, 5) == 0);
      bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
      exp_q.push_back(predict());
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL random cyc%0d: got %h want %h", i, o, e);
      end
      advance();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_mdu();
    test_branch();
    test_jump();
    test_saturation();
    test_reset_mid_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
